// File: rtl/median_pkg.sv
// Shared types and constants for the median filter stream sink.
// Frame states, error bit indices and datapath widths.
package median_pkg;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  localparam int ERR_SOF_MISSING = 0;
  localparam int ERR_EARLY_EOL   = 1;
  localparam int ERR_LATE_EOL    = 2;
  localparam int ERR_EARLY_SOF   = 3;
  localparam int ERR_CFG         = 4;
  localparam int ERR_NUM         = 5;

  localparam int IMG_DIM_W = 13;
  localparam int CHKSUM_W  = 32;

endpackage

// File: rtl/median_axis_frame_monitor.sv
// AXI4-Stream video sink: tracks frame position, flags framing
// errors, and reports per-frame checksum and frame count.
module median_axis_frame_monitor
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic [IMG_DIM_W-1:0]  WIDTH,
  input  logic [IMG_DIM_W-1:0]  HEIGHT,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  i_clear_err,
  output logic [ERR_NUM-1:0]    o_err_flags,
  output logic                  o_frame_done,
  output logic [CNT_WIDTH-1:0]  o_frame_count,
  output logic [CHKSUM_W-1:0]   o_frame_checksum,
  output logic [IMG_DIM_W-1:0]  o_x,
  output logic [IMG_DIM_W-1:0]  o_y
);

  localparam logic [IMG_DIM_W-1:0] DIM_ONE = IMG_DIM_W'(1);

  state_t               state_q, state_n;
  logic [IMG_DIM_W-1:0] w_q, w_n, h_q, h_n;
  logic [IMG_DIM_W-1:0] x_q, x_n, y_q, y_n;
  logic [IMG_DIM_W-1:0] px, py, w_e, h_e;
  logic [CHKSUM_W-1:0]  acc_q, acc_n, base, sum_q, sum_n;
  logic [ERR_NUM-1:0]   err_set, flags_q, flags_n;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_n;
  logic                 ready_q, done_n, done_q;
  logic                 beat, take, cfg_bad;
  logic                 exp_last, line_end;

  // Next-state: SOF handling, pixel accounting and frame completion
  always_comb begin
    state_n  = state_q;
    w_n      = w_q;
    h_n      = h_q;
    x_n      = x_q;
    y_n      = y_q;
    acc_n    = acc_q;
    sum_n    = sum_q;
    cnt_n    = cnt_q;
    done_n   = 1'b0;
    err_set  = '0;
    take     = 1'b0;
    px       = x_q;
    py       = y_q;
    w_e      = w_q;
    h_e      = h_q;
    base     = acc_q;
    exp_last = 1'b0;
    line_end = 1'b0;
    beat     = s_axis_tvalid && ready_q;
    cfg_bad  = (WIDTH == '0) || (HEIGHT == '0);

    if (beat) begin
      if (s_axis_tuser) begin
        err_set[ERR_EARLY_SOF] = (state_q == IN_FRAME);
        if (cfg_bad) begin
          err_set[ERR_CFG] = 1'b1;
          state_n = WAIT_SOF;
          x_n     = '0;
          y_n     = '0;
          acc_n   = '0;
        end else begin
          take    = 1'b1;
          w_e     = WIDTH;
          h_e     = HEIGHT;
          w_n     = WIDTH;
          h_n     = HEIGHT;
          px      = '0;
          py      = '0;
          base    = '0;
          state_n = IN_FRAME;
        end
      end else if (state_q == WAIT_SOF) begin
        err_set[ERR_SOF_MISSING] = 1'b1;
      end else begin
        take = 1'b1;
      end
    end

    if (take) begin
      acc_n    = base + CHKSUM_W'(s_axis_tdata);
      exp_last = (px == w_e - DIM_ONE);
      err_set[ERR_EARLY_EOL] = s_axis_tlast && !exp_last;
      err_set[ERR_LATE_EOL]  = exp_last && !s_axis_tlast;
      line_end = s_axis_tlast || exp_last;
      x_n = line_end ? '0 : px + DIM_ONE;
      y_n = line_end ? py + DIM_ONE : py;
      if (line_end && (py == h_e - DIM_ONE)) begin
        done_n  = 1'b1;
        cnt_n   = cnt_q + CNT_WIDTH'(1);
        sum_n   = acc_n;
        x_n     = '0;
        y_n     = '0;
        state_n = WAIT_SOF;
      end
    end

    flags_n = (i_clear_err ? '0 : flags_q) | err_set;
  end

  // State and status registers
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= WAIT_SOF;
      ready_q <= 1'b0;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_n;
      ready_q <= 1'b1;
      w_q     <= w_n;
      h_q     <= h_n;
      x_q     <= x_n;
      y_q     <= y_n;
      acc_q   <= acc_n;
      sum_q   <= sum_n;
      cnt_q   <= cnt_n;
      done_q  <= done_n;
      flags_q <= flags_n;
    end
  end

  assign s_axis_tready    = ready_q;
  assign o_err_flags      = flags_q;
  assign o_frame_done     = done_q;
  assign o_frame_count    = cnt_q;
  assign o_frame_checksum = sum_q;
  assign o_x              = x_q;
  assign o_y              = y_q;

endmodule

// File: tb/tb_median_axis_frame_monitor.sv
// Bench for median_axis_frame_monitor: vector table, directed
// corner sequences and random stream against a frame-level model.
module tb_median_axis_frame_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] width = 13'd4;
  logic [12:0] height = 13'd3;
  logic [7:0]  tdata = '0;
  logic        tvalid = 1'b0;
  logic        tuser = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic        clr = 1'b0;
  logic [4:0]  flags;
  logic        done;
  logic [15:0] count;
  logic [31:0] chk;
  logic [12:0] ox;
  logic [12:0] oy;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  median_axis_frame_monitor #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .i_clk(clk),
    .i_aresetn(rst_n),
    .WIDTH(width),
    .HEIGHT(height),
    .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tuser(tuser),
    .s_axis_tlast(tlast),
    .s_axis_tready(tready),
    .i_clear_err(clr),
    .o_err_flags(flags),
    .o_frame_done(done),
    .o_frame_count(count),
    .o_frame_checksum(chk),
    .o_x(ox),
    .o_y(oy)
  );

  // Reference model: frame content held as a list of pixels,
  // position as plain integer column/line counters.
  bit          m_ready;
  bit          m_in;
  int          m_w, m_h, m_col, m_line, m_count;
  int unsigned m_pix[$];
  bit          m_done;
  logic [31:0] m_sum;
  logic [4:0]  m_flags;

  function automatic logic [31:0] qsum();
    logic [31:0] s = '0;
    foreach (m_pix[i]) s += 32'(m_pix[i]);
    return s;
  endfunction

  task automatic mreset();
    m_ready = 0; m_in = 0; m_w = 0; m_h = 0;
    m_col = 0; m_line = 0; m_count = 0;
    m_pix.delete(); m_done = 0; m_sum = '0; m_flags = '0;
  endtask

  task automatic mstep(bit v, bit u, bit l, bit c,
                       logic [7:0] d, int w, int h);
    bit         tk = 0;
    logic [4:0] st = '0;
    m_done = 0;
    if (v && m_ready) begin
      if (u) begin
        if (m_in) st[3] = 1;
        m_pix.delete();
        m_col = 0;
        m_line = 0;
        if (w == 0 || h == 0) begin
          st[4] = 1;
          m_in = 0;
        end else begin
          m_in = 1; m_w = w; m_h = h; tk = 1;
        end
      end else if (!m_in) begin
        st[0] = 1;
      end else begin
        tk = 1;
      end
      if (tk) begin
        m_pix.push_back(int'(d));
        if (l && m_col != m_w - 1) st[1] = 1;
        if (!l && m_col == m_w - 1) st[2] = 1;
        if (l || m_col == m_w - 1) begin
          m_col = 0;
          if (m_line == m_h - 1) begin
            m_done = 1;
            m_count++;
            m_sum = qsum();
            m_line = 0;
            m_in = 0;
            m_pix.delete();
          end else begin
            m_line++;
          end
        end else begin
          m_col++;
        end
      end
    end
    m_flags = (c ? 5'b0 : m_flags) | st;
    m_ready = 1;
  endtask

  task automatic chk_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk_val("tready", 32'(tready), 32'(m_ready));
    chk_val("flags", 32'(flags), 32'(m_flags));
    chk_val("done", 32'(done), 32'(m_done));
    chk_val("count", 32'(count), 32'(16'(m_count)));
    chk_val("checksum", chk, m_sum);
    chk_val("x", 32'(ox), 32'(m_col));
    chk_val("y", 32'(oy), 32'(m_line));
  endtask

  task automatic step(bit v, bit u, bit l, bit c, logic [7:0] d);
    tvalid = v; tuser = u; tlast = l; clr = c; tdata = d;
    mstep(v, u, l, c, d, int'(width), int'(height));
    @(posedge clk);
    #1;
    if (done) pulses++;
  endtask

  task automatic do_reset();
    tvalid = 0; tuser = 0; tlast = 0; clr = 0;
    rst_n = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    step(0, 0, 0, 0, 8'd0);
    pulses = 0;
  endtask

  task automatic send_frame(int w, int h, int base, int npix);
    for (int i = 0; i < npix; i++) begin
      step(1, i == 0, (i % w) == w - 1, 0, 8'(base + i));
      cmp_model();
    end
  endtask

  typedef struct {
    bit          v, u, l, c;
    logic [7:0]  d;
    logic [12:0] w, h;
    logic [4:0]  ef;
    bit          ed;
    logic [12:0] ex, ey;
    logic [15:0] ec;
    logic [31:0] es;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 10, 4, 2, 5'h00, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 20, 4, 2, 5'h00, 0, 2, 0, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 30, 4, 2, 5'h02, 0, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 0, 0,  1, 4, 2, 5'h02, 0, 1, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 0,  2, 4, 2, 5'h02, 0, 2, 1, 0, 0};
    tbl[5]  = '{1, 0, 0, 0,  3, 4, 2, 5'h02, 0, 3, 1, 0, 0};
    tbl[6]  = '{1, 0, 0, 0,  4, 4, 2, 5'h06, 1, 0, 0, 1, 70};
    tbl[7]  = '{0, 0, 0, 0,  0, 4, 2, 5'h06, 0, 0, 0, 1, 70};
    tbl[8]  = '{1, 1, 0, 0,  5, 4, 0, 5'h16, 0, 0, 0, 1, 70};
    tbl[9]  = '{1, 0, 0, 1,  5, 4, 0, 5'h01, 0, 0, 0, 1, 70};
    tbl[10] = '{0, 0, 0, 0,  0, 4, 0, 5'h01, 0, 0, 0, 1, 70};

    // Reset state
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk_val("rst_tready", 32'(tready), 0);
    chk_val("rst_flags", 32'(flags), 0);
    chk_val("rst_count", 32'(count), 0);
    rst_n = 1;
    step(0, 0, 0, 0, 8'd0);
    chk_val("ready_after_rst", 32'(tready), 1);

    // Table: early/late EOL frame, then CFG error and clear-vs-set
    do_reset();
    foreach (tbl[i]) begin
      width = tbl[i].w;
      height = tbl[i].h;
      step(tbl[i].v, tbl[i].u, tbl[i].l, tbl[i].c, tbl[i].d);
      chk_val($sformatf("tbl%0d_flags", i), 32'(flags), 32'(tbl[i].ef));
      chk_val($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].ed));
      chk_val($sformatf("tbl%0d_x", i), 32'(ox), 32'(tbl[i].ex));
      chk_val($sformatf("tbl%0d_y", i), 32'(oy), 32'(tbl[i].ey));
      chk_val($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].ec));
      chk_val($sformatf("tbl%0d_sum", i), chk, tbl[i].es);
    end

    // Nominal 4x3 frame
    do_reset();
    width = 4; height = 3;
    send_frame(4, 3, 1, 12);
    chk_val("nom_done", 32'(done), 1);
    chk_val("nom_count", 32'(count), 1);
    chk_val("nom_sum", chk, 78);
    chk_val("nom_flags", 32'(flags), 0);
    chk_val("nom_xy", 32'({ox, oy}), 0);
    step(0, 0, 0, 0, 8'd0);
    chk_val("nom_done_pulse", 32'(done), 0);

    // Missing SOF then nominal frame
    do_reset();
    repeat (3) begin
      step(1, 0, 0, 0, 8'd9);
      cmp_model();
    end
    send_frame(4, 3, 1, 12);
    chk_val("miss_flags", 32'(flags), 5'b00001);
    chk_val("miss_sum", chk, 78);
    chk_val("miss_count", 32'(count), 1);

    // Early SOF abandons a partial frame
    do_reset();
    send_frame(4, 3, 50, 5);
    send_frame(4, 3, 1, 12);
    chk_val("esof_flags", 32'(flags), 5'b01000);
    chk_val("esof_pulses", 32'(pulses), 1);
    chk_val("esof_sum", chk, 78);
    chk_val("esof_count", 32'(count), 1);

    // W=1,H=1: SOF beat alone completes a frame
    do_reset();
    width = 1; height = 1;
    step(1, 1, 1, 0, 8'd200);
    chk_val("w1h1_done", 32'(done), 1);
    chk_val("w1h1_sum", chk, 200);
    cmp_model();

    // Asynchronous reset mid-frame
    do_reset();
    width = 4; height = 3;
    send_frame(4, 3, 1, 6);
    rst_n = 0;
    mreset();
    #1;
    chk_val("mid_tready", 32'(tready), 0);
    chk_val("mid_xy", 32'({ox, oy}), 0);
    chk_val("mid_misc", 32'({flags, done, count}), 0);
    chk_val("mid_sum", chk, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    step(0, 0, 0, 0, 8'd0);
    chk_val("mid_ready", 32'(tready), 1);
    send_frame(4, 3, 1, 12);
    chk_val("mid_count", 32'(count), 1);
    chk_val("mid_sum2", chk, 78);

    // Random stream against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bit v, u, l, c;
      if ($urandom_range(0, 9) == 0) begin
        width = ($urandom_range(0, 19) == 0) ? 13'd0 : 13'($urandom_range(1, 4));
        height = ($urandom_range(0, 19) == 0) ? 13'd0 : 13'($urandom_range(1, 3));
      end
      v = $urandom_range(0, 9) < 8;
      u = m_in ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) < 8);
      l = ((m_in ? m_col : 0) == (m_in ? m_w : int'(width)) - 1)
          ^ ($urandom_range(0, 11) == 0);
      c = $urandom_range(0, 29) == 0;
      step(v, u, l, c, 8'($urandom));
      cmp_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/median_axis_frame_monitor.md
Name: median_axis_frame_monitor

Overview:
- AXI4-Stream slave that terminates the video stream produced by median_5x5_top_module's master port.
- Tracks pixel/line/frame position against run-time WIDTH/HEIGHT and flags framing violations (tuser/tlast misplacement).
- Keeps a per-frame pixel checksum and a frame counter.
- Used as a sink in integration benches and as an on-chip debug status block behind the filter.

Parameters:
- DATA_WIDTH, 8, pixel width of s_axis_tdata
- CNT_WIDTH, 16, width of frame counter

Ports:
- i_clk  input  1  single clock
- i_aresetn  input  1  reset, asynchronous, active-low
- WIDTH  input  13  pixels per line, sampled at accepted SOF
- HEIGHT  input  13  lines per frame, sampled at accepted SOF
- s_axis_tdata  input  DATA_WIDTH  pixel
- s_axis_tvalid  input  1  beat valid
- s_axis_tuser  input  1  start of frame
- s_axis_tlast  input  1  end of line
- s_axis_tready  output  1  registered; 0 in reset, 1 from first clock after reset release
- i_clear_err  input  1  one-cycle pulse, clears sticky error flags
- o_err_flags  output  5  sticky: [0] SOF_MISSING, [1] EARLY_EOL, [2] LATE_EOL, [3] EARLY_SOF, [4] CFG
- o_frame_done  output  1  one-cycle pulse after last pixel of a frame
- o_frame_count  output  CNT_WIDTH  completed frames, wraps modulo 2^CNT_WIDTH
- o_frame_checksum  output  32  sum of last completed frame, updated with o_frame_done
- o_x  output  13  current column (next expected)
- o_y  output  13  current line

Behaviour:
- Beat = s_axis_tvalid && s_axis_tready. Nothing happens on cycles without a beat, except i_clear_err.
- All outputs are registered. Status reflects a beat on the clock edge after it (latency 1).
- Reset values: tready 0; flags 0; done 0; count 0; checksum 0; x 0; y 0; state WAIT_SOF.
- Reset mid-frame discards all progress; no done pulse is generated.
- FSM states: WAIT_SOF, IN_FRAME.
- WAIT_SOF, beat with tuser=0:
  - set SOF_MISSING; pixel is dropped (not summed, position unchanged).
- WAIT_SOF, beat with tuser=1:
  - If WIDTH==0 or HEIGHT==0: set CFG, drop beat, stay in WAIT_SOF.
  - Otherwise: latch W=WIDTH and H=HEIGHT; acc=tdata; y=0; handle the beat as pixel x=0 (line-end rules below); go to IN_FRAME.
- IN_FRAME, beat with tuser=1:
  - set EARLY_SOF; abandon current frame (no done, count unchanged).
  - Restart exactly as an accepted SOF from WAIT_SOF (re-latch W/H, acc=tdata).
- Per accepted pixel at column x:
  - acc += zero-extended tdata, modulo 2^32.
  - exp_last = (x==W-1).
  - tlast && !exp_last: set EARLY_EOL.
  - exp_last && !tlast: set LATE_EOL.
  - Line end = tlast || exp_last (resync on either). On line end: x=0, y=y+1; otherwise x=x+1.
- Line end with y==H-1:
  - o_frame_done=1 for one cycle; o_frame_count+1; o_frame_checksum=acc including this pixel.
  - x=0, y=0; go to WAIT_SOF.
- W=1: every pixel is a line end. W=1, H=1: SOF beat alone completes the frame.
- Error flags stay set until i_clear_err. If clear and a new error of the same bit occur in the same cycle, the error wins (flag stays 1).
- Several flags may set on one beat (e.g. EARLY_SOF and EARLY_EOL).
- WIDTH/HEIGHT changes mid-frame have no effect until the next accepted SOF.

Decomposition:
- Package median_pkg:
  - state enum (WAIT_SOF, IN_FRAME)
  - error bit index constants ERR_SOF_MISSING..ERR_CFG, ERR_NUM=5
  - IMG_DIM_W=13 and CHKSUM_W=32
- Single module; position counters and FSM are tightly coupled, so no sub-module.

Test Plan:
- Nominal: WIDTH=4, HEIGHT=3, pixels 1..12, tuser on 1, tlast on 4/8/12 -> o_frame_done one cycle after pixel 12; count=1; checksum=78; flags=0; x=y=0.
- Missing SOF: 3 beats tuser=0 (values 9), then the nominal frame -> flags=5'b00001; checksum=78; count=1.
- Early/late EOL: WIDTH=4, HEIGHT=2, tlast on 3rd pixel of line 0, then 4 pixels of line 1 with no tlast -> flags [1] and [2] set; done after 7th pixel; count=1.
- Early SOF: WIDTH=4, HEIGHT=3, 5 pixels, then full frame 1..12 starting with tuser -> flag [3] set; only one done pulse; checksum=78.
- Config and clear: HEIGHT=0 with tuser beat -> flag [4] set, state WAIT_SOF. Then i_clear_err together with a tuser=0 beat -> flags=5'b00001 (SOF_MISSING set in same cycle wins; CFG cleared).
- Reset mid-frame: assert i_aresetn=0 after 6 pixels -> tready=0 and all outputs 0 immediately. After release, tready=1 next clock; nominal frame gives count=1, checksum=78.
